// File: rtl/noc_pkg.sv
// Shared NoC constants: traffic modes, FSM encodings, timestamp width, LFSR setup.
package noc_pkg;

    // Destination patterns selected by i_mode
    localparam logic [1:0] MODE_REVERSE  = 2'd0;
    localparam logic [1:0] MODE_NEIGHBOR = 2'd1;
    localparam logic [1:0] MODE_UNIFORM  = 2'd2;
    localparam logic [1:0] MODE_HOTSPOT  = 2'd3;

    // Generator FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Inject timestamp lives in payload[TS_W-1:0]
    localparam int TS_W = 16;

    // x^16 + x^15 + x^13 + x^4 -> state bits 15, 14, 12, 3
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hD008;

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR, advances only when enabled; next_o lets the caller
// see the post-advance value in the same cycle it fires.
module noc_lfsr16
    import noc_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [15:0] state_o,
    output logic [15:0] next_o
);

    logic [15:0] state_q;

    assign next_o  = {state_q[14:0], ^(state_q & LFSR_TAPS)};
    assign state_o = state_q;

    // Shift on enable, reload seed on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    state_q <= SEED;
        else if (en_i) state_q <= next_o;
    end

endmodule

// File: rtl/pe_traffic_gen.sv
// Per-PE NoC traffic generator: rate-limited packet injection with selectable
// destination pattern, plus an always-ready ejection port that gathers
// latency statistics and flags misrouted packets.
module pe_traffic_gen
    import noc_pkg::*;
#(
    parameter int address      = 0,
    parameter int numPE        = 16,
    parameter int AddressWidth = $clog2(numPE),
    parameter int DataWidth    = 32,
    parameter int PktLimit     = 100
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_start,
    input  logic [1:0]                        i_mode,
    input  logic [7:0]                        i_rate,
    output logic [AddressWidth+DataWidth-1:0] o_data,
    output logic                              o_data_valid,
    input  logic                              i_data_ready,
    input  logic [AddressWidth+DataWidth-1:0] i_data,
    input  logic                              i_data_valid,
    output logic                              o_data_ready,
    output logic [31:0]                       o_sent_count,
    output logic [31:0]                       o_recv_count,
    output logic [31:0]                       o_latency_sum,
    output logic [15:0]                       o_latency_max,
    output logic                              o_done,
    output logic                              o_error
);

    localparam int PW = AddressWidth + DataWidth;
    localparam logic [AddressWidth-1:0] SELF = AddressWidth'(address);
    localparam logic [AddressWidth-1:0] NEXT = AddressWidth'((address + 1) % numPE);
    localparam logic [AddressWidth-1:0] REV  = AddressWidth'(numPE - 1 - address);
    localparam logic [AddressWidth-1:0] HOT  = (address == 0) ? AddressWidth'(numPE - 1) : '0;
    localparam logic [DataWidth-1:0]    SRC  = DataWidth'(address) << TS_W;
    localparam logic [31:0]             LIMIT = 32'(PktLimit);

    logic [1:0]              state_q, state_d;
    logic [TS_W-1:0]         cyc_q;
    logic [7:0]              acc_q;
    logic [2:0]              tok_q, tok_d;
    logic [PW-1:0]           data_q, pkt_d;
    logic                    valid_q, rdy_q, done_q, err_q;
    logic [31:0]             sent_q, recv_q, lsum_q, sent_nx;
    logic [15:0]             lmax_q;
    logic                    hs, earn, create;
    logic [8:0]              acc_sum;
    logic [3:0]              tok_sum;
    logic [15:0]             lfsr_q, lfsr_nx, lfsr_cur;
    logic [AddressWidth-1:0] dest_d, rx_dest;
    logic [TS_W-1:0]         lat;
    logic [32:0]             lsum_add;

    noc_lfsr16 #(.SEED(LFSR_SEED ^ 16'(address))) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (hs),
        .state_o (lfsr_q),
        .next_o  (lfsr_nx)
    );

    // Inject side bookkeeping. A packet created on the handshake edge must see
    // the post-handshake token count and LFSR value so back-to-back packets
    // at full rate neither stall nor repeat a destination.
    assign hs       = valid_q & i_data_ready;
    assign acc_sum  = {1'b0, acc_q} + {1'b0, i_rate};
    assign earn     = (state_q == ST_RUN) && ((i_rate == 8'hFF) || acc_sum[8]);
    assign tok_sum  = {1'b0, tok_q} - {3'b0, hs} + {3'b0, earn};
    assign tok_d    = (tok_sum > 4'd7) ? 3'd7 : tok_sum[2:0];
    assign sent_nx  = sent_q + {31'd0, hs};
    assign lfsr_cur = hs ? lfsr_nx : lfsr_q;
    assign create   = (state_q == ST_RUN) && (!valid_q || hs)
                    && (tok_q > 3'(hs)) && (sent_nx < LIMIT);

    // Destination for the packet being created, from the mode sampled now
    always_comb begin
        dest_d = HOT;
        case (i_mode)
            MODE_REVERSE:  dest_d = REV;
            MODE_NEIGHBOR: dest_d = NEXT;
            MODE_UNIFORM:  dest_d = (lfsr_cur[AddressWidth-1:0] == SELF) ? NEXT
                                                                        : lfsr_cur[AddressWidth-1:0];
            default:       dest_d = HOT;
        endcase
    end

    // Timestamp is the counter value in the first cycle the packet is visible
    assign pkt_d = {dest_d, SRC | DataWidth'(cyc_q + 16'd1)};

    // Run control: a single run per reset, DONE is terminal
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start) state_d = ST_RUN;
            ST_RUN:  if ((sent_q == LIMIT) && !valid_q) state_d = ST_DONE;
            default: state_d = state_q;
        endcase
    end

    // Free-running cycle counter and FSM state with registered done flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            cyc_q   <= cyc_q + 16'd1;
            state_q <= state_d;
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Rate accumulator, token bucket and the held inject packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            tok_q   <= '0;
            sent_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (state_q == ST_RUN) acc_q <= acc_sum[7:0];
            tok_q  <= tok_d;
            sent_q <= sent_nx;
            if (create) begin
                data_q  <= pkt_d;
                valid_q <= 1'b1;
            end else if (hs) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Eject side: always ready, latency stats and sticky misroute flag
    assign rx_dest  = i_data[PW-1 -: AddressWidth];
    assign lat      = cyc_q - i_data[TS_W-1:0];
    assign lsum_add = {1'b0, lsum_q} + {17'd0, lat};

    // Count every valid ejected packet regardless of FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q  <= 1'b0;
            recv_q <= '0;
            lsum_q <= '0;
            lmax_q <= '0;
            err_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (i_data_valid) begin
                recv_q <= recv_q + 32'd1;
                lsum_q <= lsum_add[32] ? 32'hFFFF_FFFF : lsum_add[31:0];
                if (lat > lmax_q)     lmax_q <= lat;
                if (rx_dest != SELF)  err_q  <= 1'b1;
            end
        end
    end

    assign o_data        = data_q;
    assign o_data_valid  = valid_q;
    assign o_data_ready  = rdy_q;
    assign o_sent_count  = sent_q;
    assign o_recv_count  = recv_q;
    assign o_latency_sum = lsum_q;
    assign o_latency_max = lmax_q;
    assign o_done        = done_q;
    assign o_error       = err_q;

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Directed bench for pe_traffic_gen: one instance at address 3 (100-packet
// runs) and one at address 5 (1000-packet uniform run) share all stimulus
// except i_start.
module tb_pe_traffic_gen;

    logic        clk, rst_n, start3, start5, ready, ivalid;
    logic [1:0]  mode;
    logic [7:0]  rate;
    logic [35:0] idata;
    logic [35:0] d3, d5;
    logic        v3, v5, r3, r5, done3, done5, err3, err5;
    logic [31:0] sent3, recv3, lsum3, sent5, recv5, lsum5;
    logic [15:0] lmax3, lmax5;
    logic [15:0] tcyc;

    int n_chk  = 0;
    int n_fail = 0;

    logic [19:0] q_pkt[$];   // expected {dest[3:0], src[15:0]}
    logic [15:0] q_lat[$];   // expected latency per ejected packet

    pe_traffic_gen #(.address(3), .numPE(16), .DataWidth(32), .PktLimit(100)) u3 (
        .clk(clk), .rst_n(rst_n), .i_start(start3), .i_mode(mode), .i_rate(rate),
        .o_data(d3), .o_data_valid(v3), .i_data_ready(ready),
        .i_data(idata), .i_data_valid(ivalid), .o_data_ready(r3),
        .o_sent_count(sent3), .o_recv_count(recv3), .o_latency_sum(lsum3),
        .o_latency_max(lmax3), .o_done(done3), .o_error(err3));

    pe_traffic_gen #(.address(5), .numPE(16), .DataWidth(32), .PktLimit(1000)) u5 (
        .clk(clk), .rst_n(rst_n), .i_start(start5), .i_mode(mode), .i_rate(rate),
        .o_data(d5), .o_data_valid(v5), .i_data_ready(ready),
        .i_data(idata), .i_data_valid(ivalid), .o_data_ready(r5),
        .o_sent_count(sent5), .o_recv_count(recv5), .o_latency_sum(lsum5),
        .o_latency_max(lmax5), .o_done(done5), .o_error(err5));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference cycle counter: same reset and edges as the DUT's counter
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcyc <= 16'd0;
        else        tcyc <= tcyc + 16'd1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start3 = 1'b0; start5 = 1'b0; ivalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int hs_n, first, last, cyc, distinct;
        int hs_at[12];
        logic [19:0] e;
        logic [35:0] snap;
        logic [31:0] exp_sum;
        logic [3:0]  dst;
        bit          seen[16];

        rst_n = 1'b0; start3 = 1'b0; start5 = 1'b0; ready = 1'b0;
        ivalid = 1'b0; idata = '0; mode = 2'd0; rate = 8'd0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_valid", v3, 0);    chk("rst_data", d3, 0);
        chk("rst_done", done3, 0);  chk("rst_error", err3, 0);
        chk("rst_ready", r3, 0);    chk("rst_sent", sent3, 0);
        chk("rst_recv", recv3, 0);  chk("rst_lsum", lsum3, 0);
        chk("rst_lmax", lmax3, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", r3, 1);
        rate = 8'hFF; ready = 1'b1; mode = 2'd0;
        repeat (5) tick();
        chk("idle_no_valid", v3, 0);
        chk("idle_no_sent", sent3, 0);

        // ---------------- REVERSE, full rate, 100 packets ----------------
        for (int i = 0; i < 100; i++) q_pkt.push_back({4'd12, 16'd3});
        start3 = 1'b1; tick(); start3 = 1'b0;
        hs_n = 0; first = -1; last = -1; cyc = 0;
        while (hs_n < 100 && cyc < 400) begin
            tick(); cyc++;
            if (v3 && ready) begin
                e = q_pkt.pop_front();
                chk("rev_dest", d3[35:32], e[19:16]);
                chk("rev_src", d3[31:16], e[15:0]);
                chk("rev_ts", d3[15:0], tcyc);
                if (first < 0) first = cyc;
                last = cyc;
                hs_n++;
            end
        end
        chk("rev_count", hs_n, 100);
        chk("rev_one_per_cycle", last - first, 99);
        tick(); chk("rev_done_plus1", done3, 0);
        tick(); chk("rev_done_plus2", done3, 1);
        chk("rev_sent", sent3, 100);
        chk("rev_valid_off", v3, 0);
        start3 = 1'b1; tick(); start3 = 1'b0;
        repeat (5) tick();
        chk("done_start_ignored", sent3, 100);
        chk("done_sticky", done3, 1);

        // ---------------- NEIGHBOR at rate 64: one per 4 cycles ----------------
        do_reset();
        q_pkt.delete();
        for (int i = 0; i < 12; i++) q_pkt.push_back({4'd4, 16'd3});
        mode = 2'd1; rate = 8'd64; ready = 1'b1;
        start3 = 1'b1; tick(); start3 = 1'b0;
        hs_n = 0; cyc = 0;
        while (hs_n < 12 && cyc < 200) begin
            tick(); cyc++;
            if (v3 && ready) begin
                e = q_pkt.pop_front();
                chk("nbr_dest", d3[35:32], e[19:16]);
                hs_at[hs_n] = cyc;
                hs_n++;
            end
        end
        chk("nbr_count", hs_n, 12);
        for (int k = 1; k < 11; k++) chk("nbr_interval", hs_at[k+1] - hs_at[k], 4);

        // ---------------- backpressure, token saturation and drain ----------------
        do_reset();
        mode = 2'd3; rate = 8'hFF; ready = 1'b0;
        start3 = 1'b1; tick(); start3 = 1'b0;
        cyc = 0;
        while (!v3 && cyc < 10) begin tick(); cyc++; end
        chk("bp_valid", v3, 1);
        chk("bp_hot_dest", d3[35:32], 0);
        snap = d3;
        mode = 2'd0;   // must not touch the pending packet
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_data_hold", d3, snap);
            chk("bp_valid_hold", v3, 1);
            chk("bp_sent_hold", sent3, 0);
        end
        rate = 8'd0; ready = 1'b1;
        hs_n = 0; first = -1; last = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (v3 && ready) begin
                chk("drain_dest", d3[35:32], 12);
                if (first < 0) first = i;
                last = i;
                hs_n++;
            end
        end
        chk("drain_sent", sent3, 7);
        chk("drain_seen", hs_n, 6);
        chk("drain_per_cycle", last - first, 5);
        chk("drain_idle", v3, 0);

        // ---------------- eject: latency wrap, max, misroute ----------------
        do_reset();
        rate = 8'd0; ready = 1'b1; mode = 2'd0; exp_sum = 0;
        cyc = 0;
        while (tcyc != 16'h0010 && cyc < 40) begin tick(); cyc++; end
        chk("lat_sync", tcyc, 16'h0010);
        idata = {4'd3, 16'd0, 16'hFFF0}; ivalid = 1'b1; q_lat.push_back(16'd32);
        tick(); ivalid = 1'b0;
        exp_sum += 32'(q_lat.pop_front());
        chk("lat_recv1", recv3, 1);
        chk("lat_sum1", lsum3, exp_sum);
        chk("lat_max1", lmax3, 32);
        chk("lat_err1", err3, 0);
        idata = {4'd7, 16'd9, tcyc - 16'd5}; ivalid = 1'b1; q_lat.push_back(16'd5);
        tick(); ivalid = 1'b0;
        exp_sum += 32'(q_lat.pop_front());
        chk("lat_recv2", recv3, 2);
        chk("lat_sum2", lsum3, exp_sum);
        chk("lat_max2", lmax3, 32);
        chk("lat_err2", err3, 1);
        idata = {4'd3, 16'd1, tcyc - 16'd100}; ivalid = 1'b1; q_lat.push_back(16'd100);
        tick(); ivalid = 1'b0;
        exp_sum += 32'(q_lat.pop_front());
        chk("lat_sum3", lsum3, exp_sum);
        chk("lat_max3", lmax3, 100);
        chk("err_sticky", err3, 1);

        // ---------------- reset mid-run with a pending packet ----------------
        do_reset();
        mode = 2'd0; rate = 8'hFF; ready = 1'b0;
        start3 = 1'b1; tick(); start3 = 1'b0;
        repeat (4) tick();
        chk("mid_pending", v3, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", v3, 0);  chk("mid_rst_data", d3, 0);
        chk("mid_rst_sent", sent3, 0); chk("mid_rst_ready", r3, 0);
        chk("mid_rst_done", done3, 0); chk("mid_rst_err", err3, 0);
        @(negedge clk);
        rst_n = 1'b1; ready = 1'b1;
        repeat (8) tick();
        chk("mid_no_restart_valid", v3, 0);
        chk("mid_no_restart_sent", sent3, 0);
        start3 = 1'b1; tick(); start3 = 1'b0;
        repeat (4) tick();
        chk("mid_restart", sent3 != 0, 1);

        // ---------------- UNIFORM at address 5, 1000 packets ----------------
        do_reset();
        mode = 2'd2; rate = 8'hFF; ready = 1'b1;
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        start5 = 1'b1; tick(); start5 = 1'b0;
        hs_n = 0; cyc = 0;
        while (hs_n < 1000 && cyc < 3000) begin
            tick(); cyc++;
            if (v5 && ready) begin
                dst = d5[35:32];
                chk("uni_not_self", dst != 4'd5, 1);
                chk("uni_range", $isunknown(dst), 0);
                seen[dst] = 1'b1;
                hs_n++;
            end
        end
        chk("uni_count", hs_n, 1000);
        distinct = 0;
        for (int i = 0; i < 16; i++) if (seen[i]) distinct++;
        chk("uni_spread", distinct >= 8, 1);
        tick(); tick();
        chk("uni_done", done5, 1);
        chk("uni_sent", sent5, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_traffic_gen.md
PE_TRAFFIC_GEN -- requirements
Module: pe_traffic_gen

Interface
REQ-001 SHALL have parameter address, default 0: this PE's network address.
REQ-002 SHALL have parameter numPE, default 16: PE count, power of two, at least 2.
REQ-003 SHALL have parameter AddressWidth, default $clog2(numPE): destination field width.
REQ-004 SHALL have parameter DataWidth, default 32: payload width, at least 16.
REQ-005 SHALL have parameter PktLimit, default 100: packets injected per run.
REQ-006 SHALL have ports clk in 1, the single clock, and rst_n in 1; reset is asynchronous and active-low.
REQ-007 SHALL have ports i_start in 1 (pulse, begins a run) and i_mode in 2 (0 REVERSE, 1 NEIGHBOR, 2 UNIFORM, 3 HOTSPOT).
REQ-008 SHALL have port i_rate in 8: injection rate; 0 is paused, 255 is every cycle.
REQ-009 SHALL have ports o_data out AddressWidth+DataWidth, o_data_valid out 1 and i_data_ready in 1 (inject side).
REQ-010 SHALL have ports i_data in AddressWidth+DataWidth, i_data_valid in 1 and o_data_ready out 1 (eject side).
REQ-011 SHALL have outputs o_sent_count 32, o_recv_count 32, o_latency_sum 32, o_latency_max 16, o_done 1 and o_error 1.

Function
REQ-012 SHALL use the packet format {destination[AddressWidth-1:0], payload}; payload[15:0] is the inject timestamp and payload[DataWidth-1:16] is the zero-extended source address.
REQ-013 SHALL run a free 16-bit cycle counter from reset; the timestamp is sampled when the packet is first presented.
REQ-014 SHALL implement the FSM IDLE->RUN on i_start; RUN->DONE when o_sent_count==PktLimit and no packet is pending; DONE stays until reset; i_start outside IDLE is ignored.
REQ-015 SHALL keep an 8-bit rate accumulator: add i_rate each RUN cycle; a carry out earns one token; i_rate==255 earns a token every cycle.
REQ-016 SHALL hold tokens in a 3-bit counter that saturates at 7 and loses excess tokens.
REQ-017 SHALL present a packet in RUN when tokens>0, o_sent_count<PktLimit and no packet is pending.
REQ-018 SHALL keep o_data and o_data_valid stable until i_data_ready; on the handshake it decrements tokens and increments o_sent_count in the same cycle.
REQ-019 SHALL compute destination as: REVERSE numPE-1-address; NEIGHBOR (address+1) mod numPE; UNIFORM LFSR[AddressWidth-1:0], replaced by (address+1) mod numPE if equal to self; HOTSPOT 0, except PE 0 sends to numPE-1.
REQ-020 SHALL use a 16-bit Fibonacci LFSR (taps 16,15,13,4) with seed 16'hACE1 XOR address; it advances only on an inject handshake.
REQ-021 SHALL sample i_mode at each packet creation; a mode change never alters a pending packet.
REQ-022 SHALL tie o_data_ready to 1 after reset (always accept) and count one packet per cycle with i_data_valid=1, in every FSM state.
REQ-023 SHALL compute latency per received packet as (cycle counter - payload[15:0]) mod 2^16.
REQ-024 SHALL add latency to o_latency_sum (saturating at 2^32-1) and raise o_latency_max when latency exceeds it.
REQ-025 SHALL set sticky o_error when a received destination differs from address; the packet is still counted.
REQ-026 SHALL assert o_done only in DONE, and o_done SHALL be registered.
REQ-027 SHALL wrap o_recv_count modulo 2^32.

Reset
REQ-028 SHALL, with rst_n=0, drive all counters, accumulator and tokens to 0, LFSR to seed, FSM to IDLE, o_data_valid=0, o_data=0, o_done=0, o_error=0 and o_data_ready=0 asynchronously.
REQ-029 SHALL abandon any pending packet on reset mid-run; after release, the first packet needs a new i_start.

Structure
REQ-030 SHALL place mode encodings, FSM state encodings, the timestamp width (16) and the LFSR seed and taps in shared package noc_pkg.
REQ-031 SHALL have one sub-module, noc_lfsr16 (enable, seed parameter, 16-bit state).

Verification
REQ-032 SHALL cover: numPE=16, address=3, REVERSE, i_rate=255, ready=1 -> 100 packets, destination 12 each, one per cycle, o_done 2 cycles after the 100th handshake.
REQ-033 SHALL cover: i_rate=64 -> exactly one injection per 4 cycles in steady state.
REQ-034 SHALL cover: ready low 10 cycles with valid high -> o_data unchanged, o_sent_count unchanged, tokens saturate at 7 then drain at one per cycle.
REQ-035 SHALL cover: UNIFORM at address=5 for 1000 packets -> no destination 5, all destinations in 0..15.
REQ-036 SHALL cover: inject packet with timestamp 16'hFFF0 at counter 16'h0010 -> latency 32, o_latency_max=32; a wrong destination sets o_error.
REQ-037 SHALL cover: rst_n pulled low mid-run with valid pending -> all outputs 0 immediately; i_start ignored until IDLE.
